// File: rtl/icap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icap_pkg
// Description : ICAP command words, controller state encoding and the
//               warm-boot / desync word tables shared by icap_seq.
// Revision    : 1.0 - initial release
// ============================================================================
package icap_pkg;

  localparam logic [31:0] ICAP_DUMMY      = 32'hFFFF_FFFF;
  localparam logic [31:0] ICAP_SYNC       = 32'hAA99_5566;
  localparam logic [31:0] ICAP_NOOP       = 32'h2000_0000;
  localparam logic [31:0] ICAP_WR_WBSTAR  = 32'h3002_0001;
  localparam logic [31:0] ICAP_WR_CMD     = 32'h3000_8001;
  localparam logic [31:0] ICAP_CMD_IPROG  = 32'h0000_000F;
  localparam logic [31:0] ICAP_CMD_DESYNC = 32'h0000_000D;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_GAP  = 3'd1;
  localparam state_t ST_SEQ  = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_TAIL = 3'd4;

  // Warm-boot word for a given slot; slot 4 carries the captured WBSTAR value.
  function automatic logic [31:0] seq_word(input logic [2:0] idx, input logic [31:0] wbstar);
    logic [31:0] w;
    case (idx)
      3'd0:    w = ICAP_DUMMY;
      3'd1:    w = ICAP_SYNC;
      3'd2:    w = ICAP_NOOP;
      3'd3:    w = ICAP_WR_WBSTAR;
      3'd4:    w = wbstar;
      3'd5:    w = ICAP_WR_CMD;
      3'd6:    w = ICAP_CMD_IPROG;
      default: w = ICAP_NOOP;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] desync_word(input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = ICAP_WR_CMD;
      2'd1:    w = ICAP_CMD_DESYNC;
      default: w = ICAP_NOOP;
    endcase
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icap_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : icap_seq_if
// Description : Host word stream (valid/ready handshake) into icap_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface icap_seq_if;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);
endinterface
`default_nettype wire

// File: rtl/icap_pacer.sv
`default_nettype none
// ============================================================================
// Module      : icap_pacer
// Description : Post-write idle gap counter, loaded with GAP on every ICAP
//               write and counting down to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module icap_pacer #(
  parameter int GAP   = 0,
  parameter int GAP_W = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_load,
  output logic      o_expired,
  output logic      o_last
);

  localparam logic [GAP_W-1:0] c_GAP_VAL = GAP_W'(GAP);

  logic [GAP_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_GAP_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - GAP_W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);
  // High in the final gap cycle so the owner can leave GAP exactly as the count hits zero.
  assign o_last    = (r_cnt == GAP_W'(1));

endmodule
`default_nettype wire

// File: rtl/icap_seq.sv
`default_nettype none
// ============================================================================
// Module      : icap_seq
// Description : ICAP write-side controller arbitrating host words and the
//               IPROG warm-boot sequence, with optional automatic DESYNC tail
//               (enabled by defining ICAP_SEQ_DESYNC_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module icap_seq
  import icap_pkg::*;
#(
  parameter int GAP   = 0,
  parameter int GAP_W = 4
) (
  input  wire logic        c,
  input  wire logic        rst_n,
  icap_seq_if.slave        i_host,
  input  wire logic        reboot,
  input  wire logic [31:0] reboot_addr,
  output logic             busy,
  output logic             icap_w,
  output logic [31:0]      icap_d
);

  localparam bit c_HAS_GAP = (GAP != 0);

  state_t      r_state;
  state_t      r_ret;
  logic [2:0]  r_idx;
  logic        r_pend;
  logic        r_run;
  logic [31:0] r_addr;
  logic        r_icap_w;
  logic [31:0] r_icap_d;

  logic        w_gap_zero;
  logic        w_gap_last;
  logic        w_host_ready;
  logic        w_accept;
  logic        w_take_reboot;
  logic        w_issue;
  logic [31:0] w_issue_data;

  icap_pacer #(
    .GAP   (GAP),
    .GAP_W (GAP_W)
  ) u_pacer (
    .clk       (c),
    .rst_n     (rst_n),
    .i_load    (w_issue),
    .o_expired (w_gap_zero),
    .o_last    (w_gap_last)
  );

  // r_run keeps ready low for the first cycle so the reset value of host_ready is 0.
  assign w_host_ready      = r_run && (r_state == ST_IDLE) && !r_pend && w_gap_zero;
  assign i_host.host_ready = w_host_ready;
  assign w_accept          = i_host.host_valid && w_host_ready;
  assign w_take_reboot     = reboot && !r_pend && (r_state != ST_DONE);

`ifdef ICAP_SEQ_DESYNC_EN
  logic       r_dirty;
  logic [4:0] r_idle;
  logic       w_start_tail;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 1'b0;
      r_idle  <= '0;
    end else if (w_accept) begin
      r_dirty <= 1'b1;
      r_idle  <= '0;
    end else if (w_start_tail) begin
      r_dirty <= 1'b0;
    end else if (r_dirty && (r_idle != 5'd16)) begin
      r_idle  <= r_idle + 5'd1;
    end
  end

  assign w_start_tail = r_dirty && (r_idle == 5'd16) && (r_state == ST_IDLE) && !r_pend && w_gap_zero;
`endif

  always_comb begin
    w_issue      = 1'b0;
    w_issue_data = r_icap_d;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_issue      = 1'b1;
          w_issue_data = i_host.host_data;
        end
      end
      ST_SEQ: begin
        w_issue      = 1'b1;
        w_issue_data = seq_word(r_idx, r_addr);
      end
`ifdef ICAP_SEQ_DESYNC_EN
      ST_TAIL: begin
        w_issue      = 1'b1;
        w_issue_data = desync_word(r_idx[1:0]);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ret    <= ST_IDLE;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_run    <= 1'b0;
      r_addr   <= '0;
      r_icap_w <= 1'b0;
      r_icap_d <= '0;
    end else begin
      r_run    <= 1'b1;
      r_icap_w <= w_issue;
      if (w_issue) begin
        r_icap_d <= w_issue_data;
      end
      // pend stays set through SEQ and DONE, so later requests cannot overwrite the address.
      if (w_take_reboot) begin
        r_pend <= 1'b1;
        r_addr <= reboot_addr;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (c_HAS_GAP) begin
              r_state <= ST_GAP;
              r_ret   <= ST_IDLE;
            end
          end else if (r_pend && w_gap_zero) begin
            r_state <= ST_SEQ;
            r_idx   <= '0;
          end
`ifdef ICAP_SEQ_DESYNC_EN
          else if (w_start_tail) begin
            r_state <= ST_TAIL;
            r_idx   <= '0;
          end
`endif
        end
        ST_GAP: begin
          if (w_gap_last) begin
            r_state <= r_ret;
          end
        end
        ST_SEQ: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state <= ST_DONE;
          end else if (c_HAS_GAP) begin
            r_state <= ST_GAP;
            r_ret   <= ST_SEQ;
          end
        end
`ifdef ICAP_SEQ_DESYNC_EN
        ST_TAIL: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd3) begin
            if (c_HAS_GAP) begin
              r_state <= ST_GAP;
              r_ret   <= ST_IDLE;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (c_HAS_GAP) begin
            r_state <= ST_GAP;
            r_ret   <= ST_TAIL;
          end
        end
`endif
        ST_DONE: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_pend || (r_state == ST_SEQ) || (r_state == ST_DONE);
  assign icap_w = r_icap_w;
  assign icap_d = r_icap_d;

endmodule
`default_nettype wire

// File: tb/tb_icap_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_icap_seq
// Description : Directed self-checking bench for icap_seq, GAP=0 and GAP=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icap_seq;

  logic c = 1'b0;
  always #5 c = ~c;

  logic        rst_n;
  logic        reboot0, reboot2;
  logic [31:0] addr0, addr2;
  logic        busy0, busy2, w0, w2;
  logic [31:0] d0, d2;

  icap_seq_if if0 ();
  icap_seq_if if2 ();

  icap_seq #(.GAP(0), .GAP_W(4)) dut0 (
    .c(c), .rst_n(rst_n), .i_host(if0.slave), .reboot(reboot0), .reboot_addr(addr0),
    .busy(busy0), .icap_w(w0), .icap_d(d0)
  );

  icap_seq #(.GAP(2), .GAP_W(4)) dut2 (
    .c(c), .rst_n(rst_n), .i_host(if2.slave), .reboot(reboot2), .reboot_addr(addr2),
    .busy(busy2), .icap_w(w2), .icap_d(d2)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] wd0[$];
  logic [31:0] wd2[$];
  int          wc0[$];
  int          wc2[$];

  // Write log: every ICAP strobe seen on either instance, with its cycle number.
  always @(posedge c) begin
    cyc <= cyc + 1;
    if (w0) begin
      wd0.push_back(d0);
      wc0.push_back(cyc);
    end
    if (w2) begin
      wd2.push_back(d2);
      wc2.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i, input logic [31:0] a);
    case (i)
      0:       return 32'hFFFF_FFFF;
      1:       return 32'hAA99_5566;
      2:       return 32'h2000_0000;
      3:       return 32'h3002_0001;
      4:       return a;
      5:       return 32'h3000_8001;
      6:       return 32'h0000_000F;
      default: return 32'h2000_0000;
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    reboot0 = 1'b0; reboot2 = 1'b0;
    addr0 = '0; addr2 = '0;
    if0.host_valid = 1'b1; if0.host_data = 32'd1;
    if2.host_valid = 1'b0; if2.host_data = '0;

    // Reset state with host_valid asserted
    repeat (3) @(negedge c);
    chk("rst_ready0", {31'd0, if0.host_ready}, 32'd0);
    chk("rst_w0",     {31'd0, w0}, 32'd0);
    chk("rst_d0",     d0, 32'd0);
    chk("rst_busy0",  {31'd0, busy0}, 32'd0);
    chk("rst_ready2", {31'd0, if2.host_ready}, 32'd0);
    rst_n = 1'b1;

    // First accept in the cycle after reset release, then back-to-back 1..4
    @(negedge c);
    chk("first_ready", {31'd0, if0.host_ready}, 32'd1);
    chk("first_nowr",  {31'd0, w0}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      if0.host_data = i;
      @(negedge c);
      chk("b2b_w", {31'd0, w0}, 32'd1);
      chk("b2b_d", d0, i);
    end
    if0.host_valid = 1'b0;
    @(negedge c);
    chk("b2b_end_w",  {31'd0, w0}, 32'd0);
    chk("b2b_hold_d", d0, 32'd4);

    // GAP=2: host_valid held, writes every 3 cycles
    wd2.delete(); wc2.delete();
    for (int i = 0; i < 3; i++) begin
      chk("gap_ready_hi", {31'd0, if2.host_ready}, 32'd1);
      if2.host_valid = 1'b1;
      if2.host_data  = 32'hA0 + i;
      @(negedge c);
      chk("gap_w",     {31'd0, w2}, 32'd1);
      chk("gap_d",     d2, 32'hA0 + i);
      chk("gap_rdy_0", {31'd0, if2.host_ready}, 32'd0);
      if (i == 2) if2.host_valid = 1'b0;
      @(negedge c);
      chk("gap_idle_w", {31'd0, w2}, 32'd0);
      chk("gap_rdy_1",  {31'd0, if2.host_ready}, 32'd0);
      @(negedge c);
    end
    chk("gap_ready_back", {31'd0, if2.host_ready}, 32'd1);
    chk("gap_count",  wd2.size(), 32'd3);
    chk("gap_space1", (wc2.size() > 1) ? wc2[1] - wc2[0] : -1, 32'd3);
    chk("gap_space2", (wc2.size() > 2) ? wc2[2] - wc2[1] : -1, 32'd3);

    // Warm boot on GAP=0 instance
    wd0.delete(); wc0.delete();
    reboot0 = 1'b1; addr0 = 32'h0040_0000;
    @(negedge c);
    reboot0 = 1'b0; addr0 = '0;
    chk("rb_busy",  {31'd0, busy0}, 32'd1);
    chk("rb_ready", {31'd0, if0.host_ready}, 32'd0);
    repeat (14) @(negedge c);
    chk("rb_count", wd0.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rb_word%0d", i), (i < wd0.size()) ? wd0[i] : 32'hDEAD_BEEF,
          exp_word(i, 32'h0040_0000));
    end
    chk("rb_span", (wc0.size() > 7) ? wc0[7] - wc0[0] : -1, 32'd7);
    if0.host_valid = 1'b1; if0.host_data = 32'h55;
    repeat (5) @(negedge c);
    chk("done_busy",  {31'd0, busy0}, 32'd1);
    chk("done_ready", {31'd0, if0.host_ready}, 32'd0);
    chk("done_nowr",  {31'd0, w0}, 32'd0);
    chk("done_count", wd0.size(), 32'd8);
    if0.host_valid = 1'b0;

    rst_n = 1'b0;
    @(negedge c);
    rst_n = 1'b1;
    @(negedge c);

    // Simultaneous reboot and host accept on GAP=2 instance, second reboot ignored
    wd2.delete(); wc2.delete();
    chk("sim_ready", {31'd0, if2.host_ready}, 32'd1);
    if2.host_valid = 1'b1; if2.host_data = 32'h1234_5678;
    reboot2 = 1'b1; addr2 = 32'h0080_0000;
    @(negedge c);
    if2.host_valid = 1'b0; reboot2 = 1'b0; addr2 = '0;
    chk("sim_w",    {31'd0, w2}, 32'd1);
    chk("sim_d",    d2, 32'h1234_5678);
    chk("sim_busy", {31'd0, busy2}, 32'd1);
    repeat (6) @(negedge c);
    reboot2 = 1'b1;
    @(negedge c);
    reboot2 = 1'b0;
    repeat (25) @(negedge c);
    chk("sim_count", wd2.size(), 32'd9);
    chk("sim_host_first", (wd2.size() > 0) ? wd2[0] : 32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("sim_word%0d", i), (i + 1 < wd2.size()) ? wd2[i+1] : 32'hDEAD_BEEF,
          exp_word(i, 32'h0080_0000));
    end
    chk("sim_seq_space", (wc2.size() > 2) ? wc2[2] - wc2[1] : -1, 32'd3);

    // Reset mid-sequence on GAP=0 instance
    wd0.delete();
    reboot0 = 1'b1; addr0 = 32'h0040_0000;
    @(negedge c);
    reboot0 = 1'b0;
    repeat (4) @(negedge c);
    chk("mid_w3", {31'd0, w0}, 32'd1);
    chk("mid_d3", d0, 32'h2000_0000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_w",     {31'd0, w0}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy0}, 32'd0);
    chk("mid_rst_d",     d0, 32'd0);
    chk("mid_rst_ready", {31'd0, if0.host_ready}, 32'd0);
    wd0.delete();
    @(negedge c);
    rst_n = 1'b1;
    repeat (10) @(negedge c);
    chk("mid_no_writes", wd0.size(), 32'd0);
    chk("mid_busy",      {31'd0, busy0}, 32'd0);
    chk("mid_ready",     {31'd0, if0.host_ready}, 32'd1);
    if0.host_valid = 1'b1; if0.host_data = 32'hCAFE_0001;
    @(negedge c);
    if0.host_valid = 1'b0;
    chk("mid_host_w", {31'd0, w0}, 32'd1);
    chk("mid_host_d", d0, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
